// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcode constants and the packed command record for the ALU command queue.
package alu_pkg;
    localparam int DW = 8;
    localparam int IW = 3;
    localparam int RW = 2 * DW;
    localparam logic [IW-1:0] OP_IDLE = 3'b000;
    localparam logic [IW-1:0] OP_ADD  = 3'b001;
    localparam logic [IW-1:0] OP_SUB  = 3'b010;
    localparam logic [IW-1:0] OP_MUL  = 3'b011;
    localparam logic [IW-1:0] OP_AND  = 3'b100;
    localparam logic [IW-1:0] OP_OR   = 3'b101;
    localparam logic [IW-1:0] OP_XOR  = 3'b110;
    localparam logic [IW-1:0] OP_NOT  = 3'b111;
    typedef struct packed {
        logic [IW-1:0] inst;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } cmd_t;
endpackage

// File: rtl/alu_cmd_queue_if.sv
// alu_cmd_queue_if: producer-side command handshake plus the ALU issue/result signals of the queue.
interface alu_cmd_queue_if import alu_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int QDW = DW,
    parameter int QIW = IW
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic           cmd_valid_i;
    logic           cmd_ready_o;
    logic [QIW-1:0] cmd_inst_i;
    logic [QDW-1:0] cmd_a_i;
    logic [QDW-1:0] cmd_b_i;
    logic           issue_en_i;
    logic           flush_i;
    logic [QIW-1:0] inst_o;
    logic [QDW-1:0] data_a_o;
    logic [QDW-1:0] data_b_o;
    logic           issue_vld_o;
    logic           result_vld_o;
    logic [CW-1:0]  count_o;
    modport slave (
        input  cmd_valid_i, cmd_inst_i, cmd_a_i, cmd_b_i, issue_en_i, flush_i,
        output cmd_ready_o, inst_o, data_a_o, data_b_o, issue_vld_o, result_vld_o, count_o
    );
    modport master (
        output cmd_valid_i, cmd_inst_i, cmd_a_i, cmd_b_i, issue_en_i, flush_i,
        input  cmd_ready_o, inst_o, data_a_o, data_b_o, issue_vld_o, result_vld_o, count_o
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: command storage with wrapping pointers and occupancy count; storage itself is not reset.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 19,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk_p_i,
    input  logic          reset_n_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic [CW-1:0] count_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    always_comb begin
        wptr_d  = flush_i ? '0 : wptr_q + PW'(push_i);
        rptr_d  = flush_i ? '0 : rptr_q + PW'(pop_i);
        count_d = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
    end
    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk_p_i) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: buffers producer commands and issues them to a latency-1 ALU, driving idle zeros when nothing issues.
module alu_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int DW = alu_pkg::DW,
    parameter int IW = alu_pkg::IW
) (
    input logic clk_p_i,
    input logic reset_n_i,
    alu_cmd_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int W = IW + 2 * DW;
    logic [CW-1:0] count;
    logic [W-1:0]  rdata, issue_q, issue_d;
    logic          ready, push, pop;
    logic          issue_vld_q, issue_vld_d, result_vld_q;
    // ready looks only at the registered count, so a full queue never accepts even while popping
    always_comb begin
        ready       = (count < CW'(DEPTH)) && !bus.flush_i;
        push        = bus.cmd_valid_i && ready;
        pop         = (count != '0) && bus.issue_en_i && !bus.flush_i;
        issue_vld_d = pop;
        issue_d     = pop ? rdata : '0;
    end
    alu_cmd_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk_p_i   (clk_p_i),
        .reset_n_i (reset_n_i),
        .push_i    (push),
        .pop_i     (pop),
        .flush_i   (bus.flush_i),
        .wdata_i   ({bus.cmd_inst_i, bus.cmd_a_i, bus.cmd_b_i}),
        .rdata_o   (rdata),
        .count_o   (count)
    );
    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            issue_q      <= '0;
            issue_vld_q  <= 1'b0;
            result_vld_q <= 1'b0;
        end else begin
            issue_q      <= issue_d;
            issue_vld_q  <= issue_vld_d;
            result_vld_q <= issue_vld_q;
        end
    end
    assign bus.cmd_ready_o  = ready;
    assign {bus.inst_o, bus.data_a_o, bus.data_b_o} = issue_q;
    assign bus.issue_vld_o  = issue_vld_q;
    assign bus.result_vld_o = result_vld_q;
    assign bus.count_o      = count;
endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb_alu_cmd_queue: directed vector table, wrap/reset sequences and a scoreboarded random run for alu_cmd_queue.
module tb_alu_cmd_queue;
    import alu_pkg::*;
    typedef struct {
        logic v;
        cmd_t c;
        logic en;
        logic fl;
        logic rdy;
        int   cnt;
        logic vld;
        cmd_t o;
        logic rv;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int ncmp = 0;
    int nerr = 0;
    vec_t tv[$];
    cmd_t q[$];

    always #5 clk = ~clk;

    alu_cmd_queue_if #(.DEPTH(4)) bus ();
    alu_cmd_queue #(.DEPTH(4), .DW(DW), .IW(IW)) dut (.clk_p_i(clk), .reset_n_i(rst_n), .bus(bus));

    function automatic cmd_t mc(int i, int a, int b);
        mc.inst = IW'(i);
        mc.a = DW'(a);
        mc.b = DW'(b);
    endfunction

    function automatic cmd_t item(int i);
        return mc(i % 8, i, i + 100);
    endfunction

    function automatic vec_t mk(logic v, cmd_t c, logic en, logic fl, logic rdy, int cnt, logic vld, cmd_t o, logic rv);
        mk.v = v; mk.c = c; mk.en = en; mk.fl = fl; mk.rdy = rdy;
        mk.cnt = cnt; mk.vld = vld; mk.o = o; mk.rv = rv;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic drive(logic v, cmd_t c, logic en, logic fl);
        @(negedge clk);
        bus.cmd_valid_i = v;
        {bus.cmd_inst_i, bus.cmd_a_i, bus.cmd_b_i} = c;
        bus.issue_en_i = en;
        bus.flush_i = fl;
        #1;
    endtask

    task automatic chk_out(string n, int cnt, logic vld, cmd_t o, logic rv);
        chk({n, " count"}, bus.count_o, cnt);
        chk({n, " issue_vld"}, bus.issue_vld_o, vld);
        chk({n, " inst"}, bus.inst_o, o.inst);
        chk({n, " a"}, bus.data_a_o, o.a);
        chk({n, " b"}, bus.data_b_o, o.b);
        chk({n, " result_vld"}, bus.result_vld_o, rv);
    endtask

    initial begin
        cmd_t z, c, eo;
        logic er, acc, ev, pv, v, en, fl;
        z = mc(0, 0, 0);
        bus.cmd_valid_i = 0; bus.cmd_inst_i = 0; bus.cmd_a_i = 0; bus.cmd_b_i = 0;
        bus.issue_en_i = 0; bus.flush_i = 0;
        // single issue and its result_vld
        tv.push_back(mk(1, mc(3, 25, 35), 1, 0, 1, 1, 0, z, 0));
        tv.push_back(mk(0, z, 1, 0, 1, 0, 1, mc(3, 25, 35), 0));
        tv.push_back(mk(0, z, 1, 0, 1, 0, 0, z, 1));
        tv.push_back(mk(0, z, 1, 0, 1, 0, 0, z, 0));
        // stall, fill to full, fifth held until a slot frees
        tv.push_back(mk(1, mc(4, 37, 128), 0, 0, 1, 1, 0, z, 0));
        tv.push_back(mk(1, mc(6, 50, 60), 0, 0, 1, 2, 0, z, 0));
        tv.push_back(mk(1, mc(6, 65, 100), 0, 0, 1, 3, 0, z, 0));
        tv.push_back(mk(1, mc(7, 65, 100), 0, 0, 1, 4, 0, z, 0));
        tv.push_back(mk(1, mc(3, 1, 2), 0, 0, 0, 4, 0, z, 0));
        tv.push_back(mk(1, mc(3, 1, 2), 0, 0, 0, 4, 0, z, 0));
        tv.push_back(mk(1, mc(3, 1, 2), 1, 0, 0, 3, 1, mc(4, 37, 128), 0));
        tv.push_back(mk(1, mc(3, 1, 2), 1, 0, 1, 3, 1, mc(6, 50, 60), 1));
        tv.push_back(mk(0, z, 1, 0, 1, 2, 1, mc(6, 65, 100), 1));
        tv.push_back(mk(0, z, 1, 0, 1, 1, 1, mc(7, 65, 100), 1));
        tv.push_back(mk(0, z, 1, 0, 1, 0, 1, mc(3, 1, 2), 1));
        tv.push_back(mk(0, z, 1, 0, 1, 0, 0, z, 1));
        tv.push_back(mk(0, z, 1, 0, 1, 0, 0, z, 0));
        // flush at count 3 with a concurrent push
        tv.push_back(mk(1, mc(1, 1, 1), 0, 0, 1, 1, 0, z, 0));
        tv.push_back(mk(1, mc(2, 2, 2), 0, 0, 1, 2, 0, z, 0));
        tv.push_back(mk(1, mc(5, 5, 5), 0, 0, 1, 3, 0, z, 0));
        tv.push_back(mk(1, mc(6, 9, 9), 1, 1, 0, 0, 0, z, 0));
        tv.push_back(mk(0, z, 1, 0, 1, 0, 0, z, 0));
        tv.push_back(mk(1, mc(7, 3, 4), 1, 0, 1, 1, 0, z, 0));
        tv.push_back(mk(0, z, 1, 0, 1, 0, 1, mc(7, 3, 4), 0));
        tv.push_back(mk(0, z, 1, 0, 1, 0, 0, z, 1));

        repeat (3) @(posedge clk);
        #1;
        chk_out("in_reset", 0, 0, z, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("ready_after_reset", bus.cmd_ready_o, 1);

        foreach (tv[i]) begin
            drive(tv[i].v, tv[i].c, tv[i].en, tv[i].fl);
            chk($sformatf("vec%0d ready", i), bus.cmd_ready_o, tv[i].rdy);
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", i), tv[i].cnt, tv[i].vld, tv[i].o, tv[i].rv);
        end

        // pointer wrap while full-ish: fill, free one slot, then push+pop for 12 cycles
        for (int i = 0; i < 4; i++) begin
            drive(1, item(i), 0, 0);
            @(posedge clk);
            #1;
            chk("wrap_fill count", bus.count_o, i + 1);
        end
        drive(1, item(4), 1, 0);
        chk("wrap_full ready", bus.cmd_ready_o, 0);
        @(posedge clk);
        #1;
        chk_out("wrap_first", 3, 1, item(0), 0);
        for (int k = 0; k < 12; k++) begin
            drive(1, item(4 + k), 1, 0);
            chk("wrap ready", bus.cmd_ready_o, 1);
            @(posedge clk);
            #1;
            chk_out($sformatf("wrap%0d", k), 3, 1, item(k + 1), 1);
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, z, 1, 0);
            @(posedge clk);
            #1;
            chk_out($sformatf("drain%0d", k), 2 - k, 1, item(13 + k), 1);
        end

        // asynchronous reset with queued entries and an issue in flight
        drive(1, mc(1, 10, 20), 0, 0);
        @(posedge clk);
        drive(1, mc(2, 30, 40), 0, 0);
        @(posedge clk);
        drive(0, z, 1, 0);
        @(posedge clk);
        #1;
        chk_out("pre_reset", 1, 1, mc(1, 10, 20), 0);
        #2 rst_n = 0;
        #1;
        chk_out("mid_reset", 0, 0, z, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("ready_after_mid_reset", bus.cmd_ready_o, 1);
        for (int k = 0; k < 2; k++) begin
            drive(0, z, 1, 0);
            @(posedge clk);
            #1;
            chk_out("post_reset", 0, 0, z, 0);
        end

        // random traffic against a queue scoreboard
        pv = 0;
        for (int n = 0; n < 1000; n++) begin
            v = ($urandom_range(0, 3) != 0);
            en = $urandom_range(0, 1);
            fl = ($urandom_range(0, 49) == 0);
            c = mc($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
            drive(v, c, en, fl);
            er = (q.size() < 4) && !fl;
            chk("rnd ready", bus.cmd_ready_o, er);
            acc = v && er;
            @(posedge clk);
            #1;
            ev = 0;
            eo = z;
            if (fl) q.delete();
            else begin
                if (q.size() > 0 && en) begin
                    ev = 1;
                    eo = q.pop_front();
                end
                if (acc) q.push_back(c);
            end
            chk_out("rnd", q.size(), ev, eo, pv);
            pv = ev;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
